// File: rtl/task1_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : task1_pkg
//  Purpose  : Shared types and constants for the ARC4 state-array initialiser.
//             Holds the init-engine state encoding and the memory geometry.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package task1_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;

    // The counter is one bit wider than the address so that the last index
    // (255) is an exact compare rather than an 8-bit overflow test.
    localparam int                CNT_W    = 9;
    localparam logic [CNT_W-1:0]  LAST_CNT = 9'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } init_state_t;

endpackage : task1_pkg
`default_nettype wire

// File: rtl/task1_if.sv
`default_nettype none
// ============================================================================
//  Module   : task1_if
//  Purpose  : Bundle between the top-level controller and the init engine.
//  Signals  : en      start request (controller -> engine)
//             rdy     engine idle and able to accept en
//             addr    memory write address
//             wrdata  memory write data
//             wren    memory write enable
//             done    one-cycle pulse while the engine sits in DONE
//  Modports : master = controller side, slave = init engine side
//  Revision : 1.0  initial release
// ============================================================================
interface task1_if;
    import task1_pkg::*;

    logic              en;
    logic              rdy;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdata;
    logic              wren;
    logic              done;

    modport master (
        output en,
        input  rdy,
        input  addr,
        input  wrdata,
        input  wren,
        input  done
    );

    modport slave (
        input  en,
        output rdy,
        output addr,
        output wrdata,
        output wren,
        output done
    );

endinterface : task1_if
`default_nettype wire

// File: rtl/task1_init.sv
`default_nettype none
// ============================================================================
//  Module   : init
//  Purpose  : Fills the state array with the identity permutation s[i] = i.
//             On an accepted start request it writes one location per cycle,
//             addresses 0..255, then spends one cycle in DONE and returns to
//             IDLE.
//  Ports    : clk   in   clock
//             rst   in   synchronous active-high reset
//             bus   slave side of task1_if (en, rdy, addr, wrdata, wren, done)
//  Revision : 1.0  initial release
// ============================================================================
module init
    import task1_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    task1_if.slave    bus
);

    init_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bus.rdy    = 1'b0;
        bus.wren   = 1'b0;
        bus.done   = 1'b0;
        bus.addr   = cnt_q[ADDR_W-1:0];
        bus.wrdata = cnt_q[DATA_W-1:0];

        case (state_q)
            IDLE: begin
                bus.rdy = 1'b1;
                if (bus.en) begin
                    cnt_d   = '0;
                    state_d = WRITE;
                end
            end

            WRITE: begin
                // Start requests here are ignored: no restart mid-fill.
                bus.wren = 1'b1;
                cnt_d    = cnt_q + 9'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : init
`default_nettype wire

// File: rtl/task1_s_mem.sv
`default_nettype none
// ============================================================================
//  Module   : s_mem
//  Purpose  : 256x8 single-port synchronous RAM, vendor-style wrapper.
//             Write-enabled store on the rising clock edge, registered read.
//             Contents are never reset.
//  Ports    : address[7:0] in   word address
//             clock        in   clock
//             data[7:0]    in   write data
//             wren         in   write enable
//             q[7:0]       out  registered read data
//  Revision : 1.0  initial release
// ============================================================================
module s_mem
    import task1_pkg::*;
(
    input  wire logic [ADDR_W-1:0] address,
    input  wire logic              clock,
    input  wire logic [DATA_W-1:0] data,
    input  wire logic              wren,
    output logic      [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clock) begin
        if (wren) begin
            mem_q[address] <= data;
        end
        q <= mem_q[address];
    end

endmodule : s_mem
`default_nettype wire

// File: rtl/task1.sv
`default_nettype none
// ============================================================================
//  Module   : task1
//  Purpose  : Board top for the ARC4 state-array initialiser. After reset is
//             released it issues a single start pulse to the init engine,
//             which fills memory s with s[i] = i. A sticky flag records
//             completion.
//  Ports    : CLOCK_50     in   system clock
//             KEY[3:0]     in   KEY[3] active-low reset, others unused
//             SW[9:0]      in   unused
//             HEX0..HEX5   out  seven-segment, active-low, held blank
//             LEDR[9:0]    out  [0] engine ready, [1] init done, [9:2] zero
//  Revision : 1.0  initial release
// ============================================================================
module task1
    import task1_pkg::*;
(
    input  wire logic       CLOCK_50,
    input  wire logic [3:0] KEY,
    input  wire logic [9:0] SW,
    output logic      [6:0] HEX0,
    output logic      [6:0] HEX1,
    output logic      [6:0] HEX2,
    output logic      [6:0] HEX3,
    output logic      [6:0] HEX4,
    output logic      [6:0] HEX5,
    output logic      [9:0] LEDR
);

    localparam logic [6:0] HEX_BLANK = 7'b1111111;

    logic rst;
    assign rst = ~KEY[3];

    // en is kept under this exact name so it can be reached hierarchically.
    logic en,        en_d;
    logic started_q, started_d;
    logic done_q,    done_d;

    task1_if bus ();

    assign bus.en = en;

    init u_init (
        .clk (CLOCK_50),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] q;

    s_mem s (
        .address (bus.addr),
        .clock   (CLOCK_50),
        .data    (bus.wrdata),
        .wren    (bus.wren),
        .q       (q)
    );

    // started_q marks that the post-reset cycle has passed, so en can only
    // ever be high in the very first cycle after reset release.
    always_comb begin
        started_d = 1'b1;
        en_d      = ~started_q & bus.rdy;
        done_d    = done_q | bus.done;
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            en        <= 1'b0;
            started_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            en        <= en_d;
            started_q <= started_d;
            done_q    <= done_d;
        end
    end

    assign HEX0 = HEX_BLANK;
    assign HEX1 = HEX_BLANK;
    assign HEX2 = HEX_BLANK;
    assign HEX3 = HEX_BLANK;
    assign HEX4 = HEX_BLANK;
    assign HEX5 = HEX_BLANK;
    assign LEDR = {8'b0, done_q, bus.rdy};

    logic unused_ok;
    assign unused_ok = &{1'b0, KEY[2:0], SW, q};

endmodule : task1
`default_nettype wire

// File: tb/tb_task1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_task1
//  Purpose  : Directed self-checking bench for task1 (identity fill of s).
//  Revision : 1.0  initial release
// ============================================================================
module tb_task1;
    import task1_pkg::*;

    logic       clk;
    logic [3:0] KEY;
    logic [9:0] SW;
    wire  [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    wire  [9:0] LEDR;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task1 dut (
        .CLOCK_50 (clk),
        .KEY      (KEY),
        .SW       (SW),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .LEDR     (LEDR)
    );

    // Observation copy of the internal controller/engine bundle.
    task1_if mon ();
    assign mon.en     = dut.en;
    assign mon.rdy    = dut.bus.rdy;
    assign mon.addr   = dut.bus.addr;
    assign mon.wrdata = dut.bus.wrdata;
    assign mon.wren   = dut.bus.wren;
    assign mon.done   = dut.bus.done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_static(input string tag);
        check({tag, "_hex"}, {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{7'b1111111}});
        check({tag, "_ledr_hi"}, LEDR[9:2], 8'h00);
    endtask

    task automatic dump_check(input string tag);
        for (int i = 0; i < MEM_DEPTH; i++) begin
            check(tag, dut.s.mem_q[8'(i)], 64'(i));
        end
    endtask

    initial begin
        int n;
        int dones;

        KEY = 4'b0111;
        SW  = 10'h000;

        // ---------------- A: automatic fill after reset release ----------
        tick(1);
        check("A_rst_ledr", LEDR, 10'h001);
        check("A_rst_en", mon.en, 1'b0);
        check("A_rst_wren", mon.wren, 1'b0);
        check_static("A_rst");
        KEY = 4'b1111;
        tick(1);
        check("A_en_pulse", mon.en, 1'b1);
        check("A_en_rdy", LEDR[0], 1'b1);
        tick(1);
        check("A_en_gone", mon.en, 1'b0);
        check("A_write_ledr", LEDR[1:0], 2'b00);
        check("A_first_wren", mon.wren, 1'b1);
        check("A_first_addr", mon.addr, 8'd0);
        tick(256);
        check("A_done_state_ledr", LEDR[1:0], 2'b00);
        check("A_done_state_wren", mon.wren, 1'b0);
        tick(1);
        check("A_final_ledr", LEDR, 10'h003);
        check_static("A_final");
        dump_check("A_dump");
        tick(5);
        check("A_idle_en", mon.en, 1'b0);
        check("A_idle_ledr", LEDR, 10'h003);

        // ---------------- B: stepwise check of each write ----------------
        KEY = 4'b0111;
        tick(1);
        check("B_rst_done_clr", LEDR[1], 1'b0);
        check("B_mem_kept", dut.s.mem_q[8'd10], 8'd10);
        KEY = 4'b1111;
        tick(1);
        check("B_en_pulse", mon.en, 1'b1);
        tick(1);
        for (int i = 0; i < MEM_DEPTH; i++) begin
            check("B_wren", mon.wren, 1'b1);
            check("B_addr", mon.addr, 64'(i));
            check("B_wrdata", mon.wrdata, 64'(i));
            tick(1);
            check("B_mem", dut.s.mem_q[8'(i)], 64'(i));
        end
        check("B_done_wren", mon.wren, 1'b0);
        check("B_done_rdy", mon.rdy, 1'b0);
        tick(1);
        check("B_final_ledr", LEDR, 10'h003);
        dump_check("B_dump");

        // ---------------- C: reset in the middle of a fill ---------------
        KEY = 4'b0111;
        tick(1);
        KEY = 4'b1111;
        tick(2);
        tick(100);
        check("C_mid_addr", mon.addr, 8'd100);
        KEY = 4'b0111;
        tick(1);
        check("C_rst_wren", mon.wren, 1'b0);
        check("C_rst_rdy", mon.rdy, 1'b1);
        check("C_rst_cnt", mon.addr, 8'd0);
        check("C_rst_done", LEDR[1], 1'b0);
        check("C_rst_en", mon.en, 1'b0);
        tick(1);
        check("C_rst2_wren", mon.wren, 1'b0);
        check_static("C_rst");
        KEY = 4'b1111;
        tick(1);
        check("C_en_pulse", mon.en, 1'b1);
        check("C_en_wren", mon.wren, 1'b0);
        tick(1);
        check("C_restart_addr", mon.addr, 8'd0);
        check("C_restart_wren", mon.wren, 1'b1);
        n = 0;
        while (LEDR[1] !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        check("C_done_cycles", 64'(n), 64'd257);
        check("C_final_ledr", LEDR, 10'h003);
        dump_check("C_dump");

        // ---------------- D: start pulse during WRITE is ignored ---------
        KEY = 4'b0111;
        tick(1);
        KEY = 4'b1111;
        tick(2);
        tick(50);
        check("D_addr50", mon.addr, 8'd50);
        force dut.en = 1'b1;
        tick(1);
        release dut.en;
        check("D_no_restart_addr", mon.addr, 8'd51);
        check("D_no_restart_wren", mon.wren, 1'b1);
        tick(204);
        check("D_addr255", mon.addr, 8'd255);
        check("D_wren255", mon.wren, 1'b1);
        dones = 0;
        repeat (20) begin
            tick(1);
            if (mon.rdy === 1'b0 && mon.wren === 1'b0) dones++;
        end
        check("D_done_once", 64'(dones), 64'd1);
        check("D_final_ledr", LEDR, 10'h003);
        check_static("D_final");
        dump_check("D_dump");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_task1
`default_nettype wire

// File: doc/task1.md
TASK1 -- requirements
Module: task1

Interface
REQ-001 The block SHALL use exactly one clock. Reset SHALL be synchronous and active-high. The internal reset SHALL be rst = ~KEY[3], because board keys are active-low.
REQ-002 CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-003 KEY  input  4  KEY[3] is the reset source (rst = ~KEY[3]); KEY[2:0] are unused.
REQ-004 SW  input  10  unused.
REQ-005 HEX0..HEX5  output  7 each  seven-segment displays, active-low; all SHALL be driven 7'b1111111 (blank).
REQ-006 LEDR  output  10  LEDR[0] = init rdy, LEDR[1] = init-done flag, LEDR[9:2] = 0.
REQ-007 Internal signal en (1 bit) SHALL be a top-level register named en, so a bench can drive it hierarchically. It is the start request to the init engine.
REQ-008 The internal memory instance SHALL be named s. It is a 256x8 single-port synchronous RAM (ports: address[7:0], clock, data[7:0], wren, q[7:0]).

Function
REQ-009 The block SHALL fill memory s so that s[i] = i for i = 0..255 (ARC4 state-array identity init).
REQ-010 While rst is high, en SHALL be 0, the done flag SHALL be 0, and the init engine SHALL be in IDLE.
REQ-011 In the first cycle after rst falls, the top SHALL assert en for exactly one cycle, provided rdy = 1. en SHALL then stay 0 until the next reset.
REQ-012 Init engine states: IDLE, WRITE, DONE.
- IDLE: rdy = 1, wren = 0.
- en = 1 in IDLE: clear the counter to 0, rdy falls next cycle, go to WRITE.
- en = 1 outside IDLE: ignored.
REQ-013 In WRITE the engine SHALL issue one write per cycle: address = counter, data = counter[7:0], wren = 1. The counter SHALL increment each cycle.
REQ-014 After the write to address 255 the engine SHALL go to DONE. The counter SHALL NOT wrap into a second pass.
REQ-015 DONE SHALL last one cycle: wren = 0, the top done flag is set (sticky until reset), then the engine returns to IDLE with rdy = 1.
REQ-016 Latency: address i SHALL be written in the (i+1)th cycle after the en pulse. All 256 locations SHALL be written within 257 cycles of en.
REQ-017 Counter width SHALL be 9 bits, so the terminal value 255 is detected without 8-bit overflow ambiguity. Only bits [7:0] drive address and data.
REQ-018 The top SHALL tie the memory's address, data and wren exclusively to the init engine. q is unused.

Reset
REQ-019 Reset asserted mid-operation SHALL return the engine to IDLE with counter = 0, wren = 0, rdy = 1 on the next clock edge. Memory contents already written are retained.
REQ-020 Reset SHALL NOT clear memory s. Re-initialisation occurs only through the automatic en pulse after reset release.
REQ-021 Every register in task1 and the init engine SHALL have a defined synchronous reset value: en = 0, done = 0, state = IDLE, counter = 0.

Structure
REQ-022 A shared package SHALL hold:
- the init state enum (IDLE, WRITE, DONE);
- constants MEM_DEPTH = 256, DATA_W = 8, ADDR_W = 8.
REQ-023 The init engine SHALL be one sub-module named init.
- Ports: clk, rst, en, rdy, addr[7:0], wrdata[7:0], wren.
- Handshake: en is accepted only when rdy = 1.
REQ-024 Memory s SHALL be a separate RAM module named s_mem (vendor single-port RAM wrapper). It is instantiated once in task1.

Verification
REQ-025 Hold KEY[3] = 0 for 1 cycle, then KEY[3] = 1: without external en forcing, after 257 cycles s[0..255] = 0..255, LEDR[1] = 1, LEDR[0] = 1.
REQ-026 Reset, then force en = 1 for one cycle, then en = 0; step one cycle at a time: each s[i] = i by cycle i+1, and the final dump of all 256 entries matches i.
REQ-027 Assert KEY[3] = 0 at cycle 100 of the fill, release it after 2 cycles: the engine restarts, final s[i] = i for all i, wren never asserts during reset.
REQ-028 Pulse en while in WRITE (cycle 50): no restart occurs, address 255 is still written at cycle 256, DONE occurs exactly once.
REQ-029 Throughout all scenarios: HEX0..HEX5 = 7'b1111111 and LEDR[9:2] = 0.
